tt_um_logic_acc: RTL and testbench

Parametrised sequential logic unit for the TinyTapeout tile, successor to the single-gate AND cell. It latches an operand and one of eight bitwise operations, folds a stream of operands into an accumulator over a configurable number of steps, then holds the result with status flags. It sits directly under the tile top-level and uses the standard tile pin set.

---
 rtl/logic_acc_pkg.sv | 36 +++
 rtl/logic_acc_alu.sv | 31 +++
 rtl/tt_um_logic_acc.sv | 113 +++++++++++
 tb/tb_tt_um_logic_acc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_acc_pkg.sv
// Shared types and pin map for the logic accumulator tile.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package logic_acc_pkg;

    // Bitwise step operations, applied as acc <= f(acc, B)
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Encodings are exported on the debug pins, so they are fixed
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // uio_in control bits (op select occupies [2:0])
    localparam int UIO_START_BIT = 3;
    localparam int UIO_STEP_BIT  = 4;
    localparam int UIO_CLEAR_BIT = 5;

    // uo_out flag bits (accumulator occupies [3:0])
    localparam int UO_DONE_BIT   = 4;
    localparam int UO_BUSY_BIT   = 5;
    localparam int UO_ZERO_BIT   = 6;
    localparam int UO_PARITY_BIT = 7;

endpackage

// File: rtl/logic_acc_alu.sv
// Combinational bitwise function y = f(op, x, y_in) for one accumulator step.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module logic_acc_alu
    import logic_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] f
);

    // Select one of the eight bitwise combinations of accumulator and operand
    always_comb begin
        f = x;
        case (op_e'(op))
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_XOR:  f = x ^ y;
            OP_NAND: f = ~(x & y);
            OP_NOR:  f = ~(x | y);
            OP_XNOR: f = ~(x ^ y);
            OP_ANDN: f = x & ~y;
            OP_PASS: f = y;
            default: f = x;
        endcase
    end

endmodule

// File: rtl/tt_um_logic_acc.sv
// Sequential logic accumulator tile: start latches A and op, steps fold B in, DONE holds result + flags.
// Latency: start/step/clear sampled at edge t are visible on uo_out from t+1; outputs fully registered.
// Backpressure: none; steps outside RUN are dropped. Optional LOGIC_ACC_DEBUG_EN exports state on uio_out[7:6].
module tt_um_logic_acc
    import logic_acc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             start_q;
    logic             start_pulse;
    logic             step;
    logic             clear;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] alu_f;
    logic [3:0]       acc_pad;
    logic             unused_ok;

    assign opnd_a      = ui_in[WIDTH-1:0];
    assign opnd_b      = ui_in[4+WIDTH-1:4];
    assign step        = uio_in[UIO_STEP_BIT];
    assign clear       = uio_in[UIO_CLEAR_BIT];
    assign start_pulse = uio_in[UIO_START_BIT] & ~start_q;

    // ena is tied high on the tile; spare input bits are deliberately ignored
    assign unused_ok = &{1'b0, ena, ui_in, uio_in};

    logic_acc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op (op_q),
        .x  (acc_q),
        .y  (opnd_b),
        .f  (alu_f)
    );

    // Next-state: clear beats start pulse, start pulse beats step
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (start_pulse) begin
            state_d = ST_RUN;
            acc_d   = opnd_a;
            cnt_d   = '0;
            op_d    = uio_in[2:0];
        end else if (state_q == ST_RUN && step) begin
            acc_d = alu_f;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NUM_OPS - 1)) begin
                state_d = ST_DONE;
            end
        end
    end

    // State, accumulator, step counter, latched op and start edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            start_q <= uio_in[UIO_START_BIT];
        end
    end

    // Result and flags decoded from registered state only
    always_comb begin
        acc_pad                = 4'(acc_q);
        uo_out                 = {4'b0000, acc_pad};
        uo_out[UO_DONE_BIT]    = (state_q == ST_DONE);
        uo_out[UO_BUSY_BIT]    = (state_q == ST_RUN);
        uo_out[UO_ZERO_BIT]    = (state_q == ST_DONE) && (acc_q == '0);
        uo_out[UO_PARITY_BIT]  = (state_q == ST_DONE) && (^acc_q);
    end

`ifdef LOGIC_ACC_DEBUG_EN
    assign uio_out = {state_q, 6'b000000};
    assign uio_oe  = 8'b1100_0000;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_logic_acc.sv
// Directed bench: the driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_tt_um_logic_acc;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena   = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    tt_um_logic_acc #(.WIDTH(4), .NUM_OPS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    int n_vec   = 0;
    int n_bad   = 0;

    int         due_q[$];
    logic [7:0] uo_q[$];
    logic [1:0] st_q[$];
    string      name_q[$];

    always @(posedge clk) cyc_cnt++;

    function automatic logic [7:0] exp_uo(input logic [3:0] acc, input logic [1:0] st);
        logic d;
        d = (st == S_DONE);
        return {d & (^acc), d & (acc == 4'h0), (st == S_RUN), d, acc};
    endfunction

    function automatic logic [7:0] exp_dbg(input logic [1:0] st);
`ifdef LOGIC_ACC_DEBUG_EN
        return {st, 6'b000000};
`else
        return 8'h00 & {st, 6'b000000};
`endif
    endfunction

    function automatic logic [7:0] exp_oe();
`ifdef LOGIC_ACC_DEBUG_EN
        return 8'hC0;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] uo_e, input logic [1:0] st);
        logic [7:0] dbg_e;
        logic [7:0] oe_e;
        dbg_e = exp_dbg(st);
        oe_e  = exp_oe();
        n_vec++;
        if (uo_out !== uo_e || uio_out !== dbg_e || uio_oe !== oe_e) begin
            n_bad++;
            $display("FAIL %s: got uo_out=%02h uio_out=%02h uio_oe=%02h, want %02h %02h %02h",
                     name, uo_out, uio_out, uio_oe, uo_e, dbg_e, oe_e);
        end
    endtask

    // Monitor: compare every expectation due on the edge just passed
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc_cnt) begin
            if (due_q[0] < cyc_cnt) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         name_q[0], due_q[0], cyc_cnt);
            end else begin
                check(name_q[0], uo_q[0], st_q[0]);
            end
            void'(due_q.pop_front());
            void'(uo_q.pop_front());
            void'(st_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic start, input logic step, input logic clear,
                         input logic [3:0] acc, input logic [1:0] st, input string name);
        ui_in  = {b, a};
        uio_in = {2'b00, clear, step, start, op};
        due_q.push_back(cyc_cnt + 1);
        uo_q.push_back(exp_uo(acc, st));
        st_q.push_back(st);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    // Per-op runs: B for step i in [4i+:4], expected acc after step i likewise
    logic [2:0]  t_op [5] = '{3'd3, 3'd5, 3'd6, 3'd4, 3'd7};
    logic [3:0]  t_a  [5] = '{4'hC, 4'h0, 4'hF, 4'h0, 4'h0};
    logic [15:0] t_b  [5] = '{16'hF3FA, 16'hC355, 16'h0421, 16'h1080, 16'h8421};
    logic [15:0] t_acc[5] = '{16'h0F87, 16'hFC0A, 16'h88CE, 16'h0F0F, 16'h8421};

    initial begin
        // Reset with a real falling edge so the async path is exercised
        #2 rst_n = 1'b0;
        #1 check("reset_initial", 8'h00, S_IDLE);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // AND run: F & E & D & B & 7 -> 0, done+zero
        drive(4'hF, 4'h0, 3'd0, 1, 0, 0, 4'hF, S_RUN,  "and_start");
        drive(4'h0, 4'hE, 3'd0, 0, 1, 0, 4'hE, S_RUN,  "and_s1");
        drive(4'h0, 4'hD, 3'd0, 0, 1, 0, 4'hC, S_RUN,  "and_s2");
        drive(4'h0, 4'hB, 3'd0, 0, 1, 0, 4'h8, S_RUN,  "and_s3");
        drive(4'h0, 4'h7, 3'd0, 0, 1, 0, 4'h0, S_DONE, "and_s4_done");
        drive(4'h0, 4'h7, 3'd0, 0, 0, 0, 4'h0, S_DONE, "and_hold");

        // XOR with gaps; op select wiggled mid-run must not matter
        drive(4'h5, 4'h3, 3'd2, 1, 0, 0, 4'h5, S_RUN,  "xor_start");
        drive(4'h5, 4'h3, 3'd2, 0, 1, 0, 4'h6, S_RUN,  "xor_c1");
        drive(4'h5, 4'h3, 3'd0, 0, 0, 0, 4'h6, S_RUN,  "xor_gap2");
        drive(4'h5, 4'h3, 3'd0, 0, 1, 0, 4'h5, S_RUN,  "xor_c3");
        drive(4'h5, 4'h3, 3'd7, 0, 1, 0, 4'h6, S_RUN,  "xor_c4");
        drive(4'h5, 4'h3, 3'd7, 0, 0, 0, 4'h6, S_RUN,  "xor_gap5");
        drive(4'h5, 4'h3, 3'd1, 0, 0, 0, 4'h6, S_RUN,  "xor_gap6");
        drive(4'h5, 4'h3, 3'd1, 0, 1, 0, 4'h5, S_DONE, "xor_c7_done");

        // Clear to IDLE, then hold start for 5 cycles: a single restart only
        drive(4'h0, 4'h0, 3'd0, 0, 0, 1, 4'h0, S_IDLE, "clear_from_done");
        drive(4'h9, 4'h0, 3'd1, 1, 0, 0, 4'h9, S_RUN,  "hold_start1");
        drive(4'h9, 4'h0, 3'd1, 1, 0, 0, 4'h9, S_RUN,  "hold_start2");
        drive(4'h3, 4'h0, 3'd2, 1, 0, 0, 4'h9, S_RUN,  "hold_start3");
        drive(4'h3, 4'h0, 3'd2, 1, 0, 0, 4'h9, S_RUN,  "hold_start4");
        drive(4'h3, 4'h0, 3'd2, 1, 0, 0, 4'h9, S_RUN,  "hold_start5");
        // Count still 0: exactly four OR-0 steps are needed to finish
        drive(4'h3, 4'h0, 3'd2, 0, 1, 0, 4'h9, S_RUN,  "hold_s1");
        drive(4'h3, 4'h0, 3'd2, 0, 1, 0, 4'h9, S_RUN,  "hold_s2");
        drive(4'h3, 4'h0, 3'd2, 0, 1, 0, 4'h9, S_RUN,  "hold_s3");
        drive(4'h3, 4'h0, 3'd2, 0, 1, 0, 4'h9, S_DONE, "hold_s4_done");

        // Clear + start + step during RUN -> IDLE
        drive(4'h6, 4'h1, 3'd2, 1, 0, 0, 4'h6, S_RUN,  "csx_start");
        drive(4'h6, 4'h1, 3'd2, 0, 1, 0, 4'h7, S_RUN,  "csx_step");
        drive(4'h6, 4'h1, 3'd2, 1, 1, 1, 4'h0, S_IDLE, "csx_clear_wins");
        drive(4'h6, 4'h1, 3'd2, 0, 0, 0, 4'h0, S_IDLE, "csx_idle");

        // Reach DONE, then start + step together: step must be dropped
        drive(4'hF, 4'hF, 3'd0, 1, 0, 0, 4'hF, S_RUN,  "ss_start");
        for (int i = 0; i < 4; i++)
            drive(4'hF, 4'hF, 3'd0, 0, 1, 0, 4'hF, (i == 3) ? S_DONE : S_RUN, "ss_fill");
        drive(4'h3, 4'h0, 3'd0, 1, 1, 0, 4'h3, S_RUN,  "ss_start_step");
        for (int i = 0; i < 4; i++)
            drive(4'h3, 4'hF, 3'd0, 0, 1, 0, 4'h3, (i == 3) ? S_DONE : S_RUN, "ss_recount");
        drive(4'h3, 4'h0, 3'd0, 0, 1, 0, 4'h3, S_DONE, "step_in_done");

        // Remaining ops, four steps each
        for (int r = 0; r < 5; r++) begin
            drive(t_a[r], 4'h0, t_op[r], 1, 0, 0, t_a[r], S_RUN, "op_start");
            for (int i = 0; i < 4; i++)
                drive(4'h0, t_b[r][4*i +: 4], 3'd0, 0, 1, 0, t_acc[r][4*i +: 4],
                      (i == 3) ? S_DONE : S_RUN, "op_step");
        end

        // Reset mid-run: outputs drop immediately, IDLE afterwards
        drive(4'hA, 4'h5, 3'd1, 1, 0, 0, 4'hA, S_RUN,  "rst_run_start");
        drive(4'hA, 4'h5, 3'd1, 0, 1, 0, 4'hF, S_RUN,  "rst_run_step");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_run", 8'h00, S_IDLE);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(4'hA, 4'h5, 3'd1, 0, 0, 0, 4'h0, S_IDLE, "post_reset_idle");
        drive(4'hA, 4'hF, 3'd1, 0, 1, 0, 4'h0, S_IDLE, "step_in_idle");
        drive(4'h0, 4'h0, 3'd0, 0, 0, 0, 4'h0, S_IDLE, "tail");

        @(negedge clk);
        #1;
        if (due_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", due_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
